// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard control: load-use stall, taken-branch flush and data-memory freeze with timeout.
// Latency: outputs are combinational from inputs and state; release adds zero cycles. Optional HAZ_PERF_CNT_EN adds stall_cycles.
// Backpressure: dmem_ready low freezes every stage up to EX/MEM; a freeze of TIMEOUT+1 cycles locks into ERROR until reset.
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       ID_Rn,
    input  logic [4:0]       ID_Rm,
    input  logic             ID_uses_Rm,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_WR,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IDEX_Write,
    output logic             EXMEM_Write,
    output logic             MEMWB_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Bubble,
    output logic             MEMWB_Bubble,
    output logic             mem_error
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        ERROR = 2'd2
    } state_t;

    if (TIMEOUT < 2 || TIMEOUT > 255 || CNT_W < 1) begin : g_bad_param
        $error("pipeline_hazard_ctrl: TIMEOUT must be 2..255 and CNT_W at least 1");
    end

    state_t     state, state_nxt;
    logic [7:0] timer, timer_nxt;
    logic       load_use;
    logic       memstall;

    // Unfrozen control for the current inputs: branch beats load-use beats normal flow.
    logic run_pc_wr, run_ifid_wr, run_ifid_flush, run_idex_bubble;

    assign load_use = EX_MemRead && (EX_WR != 5'd31) &&
                      ((EX_WR == ID_Rn) || (ID_uses_Rm && (EX_WR == ID_Rm)));
    assign memstall = dmem_req && !dmem_ready;

    always_comb begin
        run_pc_wr       = 1'b1;
        run_ifid_wr     = 1'b1;
        run_ifid_flush  = 1'b0;
        run_idex_bubble = 1'b0;
        if (branch_taken) begin
            run_ifid_flush  = 1'b1;
            run_idex_bubble = 1'b1;
        end else if (load_use) begin
            run_pc_wr       = 1'b0;
            run_ifid_wr     = 1'b0;
            run_idex_bubble = 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        PCWrite      = run_pc_wr;
        IFID_Write   = run_ifid_wr;
        IDEX_Write   = 1'b1;
        EXMEM_Write  = 1'b1;
        MEMWB_Write  = 1'b1;
        IFID_Flush   = run_ifid_flush;
        IDEX_Bubble  = run_idex_bubble;
        MEMWB_Bubble = 1'b0;

        case (state)
            RUN: begin
                if (memstall) begin
                    state_nxt = WAIT;
                    timer_nxt = 8'd0;
                end
            end
            WAIT: begin
                if (!dmem_ready) begin
                    timer_nxt = timer + 8'd1;
                    if (timer == 8'(TIMEOUT - 1)) begin
                        state_nxt = ERROR;
                    end
                end else begin
                    state_nxt = RUN;
                end
            end
            ERROR: begin
                MEMWB_Write = 1'b0;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        // A freeze holds everything up to EX/MEM and drains a bubble into MEM/WB;
        // a branch sitting in EX waits in IDEX and is honoured on release.
        if ((state == RUN && memstall) || (state == WAIT && !dmem_ready) || state == ERROR) begin
            PCWrite      = 1'b0;
            IFID_Write   = 1'b0;
            IDEX_Write   = 1'b0;
            EXMEM_Write  = 1'b0;
            IFID_Flush   = 1'b0;
            IDEX_Bubble  = 1'b0;
            MEMWB_Bubble = 1'b1;
        end

        if (reset) begin
            PCWrite      = 1'b0;
            IFID_Write   = 1'b0;
            IDEX_Write   = 1'b0;
            EXMEM_Write  = 1'b0;
            MEMWB_Write  = 1'b0;
            IFID_Flush   = 1'b1;
            IDEX_Bubble  = 1'b1;
            MEMWB_Bubble = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= RUN;
            timer     <= 8'd0;
            mem_error <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            if (state_nxt == ERROR) begin
                mem_error <= 1'b1;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (!PCWrite && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic vs a cycle-count model.
module tb_pipeline_hazard_ctrl;

    localparam int TO       = 15;
    localparam int TB_CNT_W = 4;
    localparam int PERF_MAX = (1 << TB_CNT_W) - 1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rn = '0, id_rm = '0, ex_wr = '0;
    logic       id_uses_rm = 1'b0, ex_memread = 1'b0, branch_taken = 1'b0;
    logic       dmem_req = 1'b0, dmem_ready = 1'b0;

    logic PCWrite, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write;
    logic IFID_Flush, IDEX_Bubble, MEMWB_Bubble, mem_error;
`ifdef HAZ_PERF_CNT_EN
    logic [TB_CNT_W-1:0] stall_cycles;
`endif

    int errors = 0;
    int checks = 0;

    // Model state: length of the current freeze, error latch, stall count.
    int m_age  = 0;
    bit m_err  = 1'b0;
    int m_perf = 0;

    pipeline_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(TB_CNT_W)) dut (
        .clock(clock), .reset(reset),
        .ID_Rn(id_rn), .ID_Rm(id_rm), .ID_uses_Rm(id_uses_rm),
        .EX_MemRead(ex_memread), .EX_WR(ex_wr), .branch_taken(branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IDEX_Write(IDEX_Write),
        .EXMEM_Write(EXMEM_Write), .MEMWB_Write(MEMWB_Write),
        .IFID_Flush(IFID_Flush), .IDEX_Bubble(IDEX_Bubble),
        .MEMWB_Bubble(MEMWB_Bubble), .mem_error(mem_error)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    // Bit order: {PCWrite, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write,
    //             IFID_Flush, IDEX_Bubble, MEMWB_Bubble, mem_error}
    function automatic bit model_frozen();
        if (m_age == 0) return dmem_req && !dmem_ready;
        return !dmem_ready;
    endfunction

    function automatic logic [8:0] model_out();
        bit lu;
        lu = ex_memread && (ex_wr != 5'd31) &&
             ((ex_wr == id_rn) || (id_uses_rm && (ex_wr == id_rm)));
        if (reset)          return {5'b00000, 3'b111, m_err};
        if (m_err)          return 9'b00000_0011;
        if (model_frozen()) return 9'b00001_0010;
        if (branch_taken)   return 9'b11111_1100;
        if (lu)             return 9'b00111_0100;
        return 9'b11111_0000;
    endfunction

    // Samples outputs late in the cycle, advances the model across the edge, returns at the next negedge.
    task automatic tick(output logic [8:0] exp_o, output logic [8:0] got_o);
        bit frz;
        #2;
        got_o = {PCWrite, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write,
                 IFID_Flush, IDEX_Bubble, MEMWB_Bubble, mem_error};
        exp_o = model_out();
        frz   = model_frozen();
        @(posedge clock);
        if (reset) begin
            m_age = 0; m_err = 1'b0; m_perf = 0;
        end else begin
            if (!exp_o[8] && m_perf < PERF_MAX) m_perf++;
            if (!m_err) begin
                if (frz) begin
                    m_age++;
                    if (m_age == TO + 1) m_err = 1'b1;
                end else begin
                    m_age = 0;
                end
            end
        end
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        id_rn = 5'd0; id_rm = 5'd0; ex_wr = 5'd0; id_uses_rm = 1'b0;
        ex_memread = 1'b0; branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] e, g;
        idle_inputs();
        reset = 1'b1;
        tick(e, g);
        tick(e, g);
        checks++;
        if (g !== 9'b00000_1110) begin
            errors++; $display("FAIL reset_outputs: got %b expected %b", g, 9'b00000_1110);
        end
        reset = 1'b0;
        tick(e, g);
        checks++;
        if (g !== 9'b11111_0000) begin
            errors++; $display("FAIL reset_release: got %b expected %b", g, 9'b11111_0000);
        end
    endtask

    task automatic test_load_use();
        logic [8:0] e, g;
        idle_inputs();
        ex_memread = 1'b1; ex_wr = 5'd3; id_rn = 5'd3;
        tick(e, g);
        checks++;
        if (g !== 9'b00111_0100) begin
            errors++; $display("FAIL load_use_rn: got %b expected %b", g, 9'b00111_0100);
        end
        idle_inputs();
        tick(e, g);
        checks++;
        if (g !== 9'b11111_0000) begin
            errors++; $display("FAIL load_use_after: got %b expected %b", g, 9'b11111_0000);
        end
        ex_memread = 1'b1; ex_wr = 5'd31; id_rn = 5'd31;
        tick(e, g);
        checks++;
        if (g !== 9'b11111_0000) begin
            errors++; $display("FAIL load_use_r31: got %b expected %b", g, 9'b11111_0000);
        end
        ex_wr = 5'd7; id_rn = 5'd1; id_rm = 5'd7; id_uses_rm = 1'b0;
        tick(e, g);
        checks++;
        if (g !== 9'b11111_0000) begin
            errors++; $display("FAIL load_use_rm_unused: got %b expected %b", g, 9'b11111_0000);
        end
        id_uses_rm = 1'b1;
        tick(e, g);
        checks++;
        if (g !== 9'b00111_0100) begin
            errors++; $display("FAIL load_use_rm_used: got %b expected %b", g, 9'b00111_0100);
        end
        idle_inputs();
    endtask

    task automatic test_branch_priority();
        logic [8:0] e, g;
        idle_inputs();
        ex_memread = 1'b1; ex_wr = 5'd4; id_rn = 5'd4; branch_taken = 1'b1;
        tick(e, g);
        checks++;
        if (g !== 9'b11111_1100) begin
            errors++; $display("FAIL branch_over_load_use: got %b expected %b", g, 9'b11111_1100);
        end
        idle_inputs();
        dmem_req = 1'b0; dmem_ready = 1'b1; branch_taken = 1'b1;
        tick(e, g);
        checks++;
        if (g !== 9'b11111_1100) begin
            errors++; $display("FAIL ready_without_req: got %b expected %b", g, 9'b11111_1100);
        end
        idle_inputs();
    endtask

    task automatic test_mem_stall();
        logic [8:0] e, g;
        int frozen_seen = 0;
        int flush_seen  = 0;
        idle_inputs();
        dmem_req = 1'b1; dmem_ready = 1'b0; branch_taken = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) dmem_ready = 1'b1;
            tick(e, g);
            checks++;
            if (g !== e) begin
                errors++; $display("FAIL mem_stall cycle %0d: got %b expected %b", c, g, e);
            end
            if (g[8] == 1'b0 && g[1] == 1'b1) frozen_seen++;
            if (g[3] == 1'b1) flush_seen++;
            if (c == 5) begin
                checks++;
                if (g !== 9'b11111_1100) begin
                    errors++; $display("FAIL mem_stall_release: got %b expected %b", g, 9'b11111_1100);
                end
            end
        end
        checks++;
        if (frozen_seen != 4 || flush_seen != 1) begin
            errors++;
            $display("FAIL mem_stall_counts: frozen %0d flush %0d, expected frozen 4 flush 1", frozen_seen, flush_seen);
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        logic [8:0] e, g;
        idle_inputs();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int c = 1; c <= TO + 4; c++) begin
            tick(e, g);
            checks++;
            if (g !== e) begin
                errors++; $display("FAIL timeout cycle %0d: got %b expected %b", c, g, e);
            end
            if (c == TO + 1) begin
                checks++;
                if (g[0] !== 1'b0) begin
                    errors++; $display("FAIL timeout_early: mem_error %b at cycle %0d, expected 0", g[0], c);
                end
            end
            if (c == TO + 2) dmem_ready = 1'b1;
        end
        checks++;
        if (g !== 9'b00000_0011) begin
            errors++; $display("FAIL timeout_sticky: got %b expected %b", g, 9'b00000_0011);
        end
        reset = 1'b1;
        tick(e, g);
        reset = 1'b0;
        idle_inputs();
        tick(e, g);
        checks++;
        if (g !== 9'b11111_0000) begin
            errors++; $display("FAIL timeout_reset: got %b expected %b", g, 9'b11111_0000);
        end
    endtask

    task automatic test_perf_saturation();
`ifdef HAZ_PERF_CNT_EN
        logic [8:0] e, g;
        idle_inputs();
        reset = 1'b1;
        tick(e, g);
        reset = 1'b0;
        ex_memread = 1'b1; ex_wr = 5'd3; id_rn = 5'd3;
        for (int c = 0; c < 20; c++) tick(e, g);
        checks++;
        if (stall_cycles !== 4'd15) begin
            errors++; $display("FAIL perf_saturate: got %0d expected 15", stall_cycles);
        end
        idle_inputs();
`endif
    endtask

    function automatic logic [4:0] pick_reg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 5'd31 : 5'(r);
    endfunction

    task automatic test_random();
        logic [8:0] e, g;
        for (int c = 0; c < 3000; c++) begin
            reset        = ($urandom_range(0, 99) == 0);
            id_rn        = pick_reg();
            id_rm        = pick_reg();
            ex_wr        = pick_reg();
            id_uses_rm   = 1'($urandom_range(0, 1));
            ex_memread   = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 3) == 0);
            dmem_req     = 1'($urandom_range(0, 1));
            // Occasional long waits so the timeout path is exercised.
            dmem_ready   = (c % 400 < 30) ? 1'b0 : ($urandom_range(0, 2) != 0);
`ifdef HAZ_PERF_CNT_EN
            checks++;
            if (stall_cycles !== TB_CNT_W'(m_perf)) begin
                errors++; $display("FAIL rand_perf cycle %0d: got %0d expected %0d", c, stall_cycles, m_perf);
            end
`endif
            tick(e, g);
            checks++;
            if (g !== e) begin
                errors++; $display("FAIL rand cycle %0d: got %b expected %b", c, g, e);
            end
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_load_use();
        test_branch_priority();
        test_mem_stall();
        test_timeout();
        test_perf_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
